// File: rtl/multicycle_pkg.sv
// Shared encodings for the multicycle RV32I-subset controller: FSM states,
// opcodes, datapath select codes and the per-state control word.
package multicycle_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMREAD,
        MEMWB,
        MEMWRITE,
        EXEC_R,
        EXEC_I,
        ALU_WB,
        LUI,
        BRANCH,
        JAL,
        JALR,
        LINK
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_LBU  = 3'b100;
    localparam logic [2:0] F3_SB   = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BGEU = 3'b111;
    localparam logic [2:0] F3_JALR = 3'b000;

    localparam logic [2:0] ALU_ADD    = 3'b000;
    localparam logic [2:0] ALU_SUB    = 3'b001;
    localparam logic [2:0] ALU_PASS_B = 3'b010;
    localparam logic [2:0] ALU_SLTU   = 3'b011;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_READDATA  = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    // in_* flags mark states whose strobes are qualified by live inputs
    typedef struct packed {
        logic       pc_write;
        logic       adr_src;
        logic       mem_req;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] imm_src;
        logic [1:0] result_src;
        logic [2:0] alu_control;
        logic       in_fetch;
        logic       in_decode;
        logic       in_branch;
    } ctrl_t;

    function automatic ctrl_t state_ctrl(state_t s, logic [6:0] opcode, logic [2:0] branch_alu);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.mem_req    = 1'b1;
                c.alu_src_a  = SRCA_PC;
                c.alu_src_b  = SRCB_FOUR;
                c.result_src = RES_ALURESULT;
                c.in_fetch   = 1'b1;
            end
            DECODE: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_IMM;
                c.in_decode = 1'b1;
            end
            MEMADR: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_IMM;
                c.imm_src   = (opcode == OP_LOAD) ? IMM_I : IMM_S;
            end
            MEMREAD: begin
                c.mem_req = 1'b1;
                c.adr_src = 1'b1;
            end
            MEMWB: begin
                c.reg_write  = 1'b1;
                c.result_src = RES_READDATA;
            end
            MEMWRITE: begin
                c.mem_req   = 1'b1;
                c.mem_write = 1'b1;
                c.adr_src   = 1'b1;
            end
            EXEC_R: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_RS2;
            end
            EXEC_I: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_IMM;
                c.imm_src   = IMM_I;
            end
            ALU_WB: begin
                c.reg_write  = 1'b1;
                c.result_src = RES_ALUOUT;
            end
            LUI: begin
                c.alu_src_b   = SRCB_IMM;
                c.imm_src     = IMM_U;
                c.alu_control = ALU_PASS_B;
                c.result_src  = RES_ALURESULT;
                c.reg_write   = 1'b1;
            end
            BRANCH: begin
                c.alu_src_a   = SRCA_RS1;
                c.alu_src_b   = SRCB_RS2;
                c.alu_control = branch_alu;
                c.result_src  = RES_ALUOUT;
                c.in_branch   = 1'b1;
            end
            JAL: begin
                c.pc_write   = 1'b1;
                c.result_src = RES_ALUOUT;
                c.alu_src_a  = SRCA_OLDPC;
                c.alu_src_b  = SRCB_FOUR;
            end
            JALR: begin
                c.alu_src_a  = SRCA_RS1;
                c.alu_src_b  = SRCB_IMM;
                c.imm_src    = IMM_I;
                c.result_src = RES_ALURESULT;
                c.pc_write   = 1'b1;
            end
            LINK: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_FOUR;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mc_branch_eval.sv
// Branch condition evaluation: picks the comparison ALU op for bne/bgeu and
// decides taken from the ALU zero flag.
module mc_branch_eval
    import multicycle_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       zero,
    output logic       taken,
    output logic [2:0] alu_op
);

    always_comb begin
        taken  = 1'b0;
        alu_op = ALU_SUB;
        case (funct3)
            F3_BNE: taken = ~zero;
            // SLTU yields 0 when rs1 >= rs2, so zero=1 means bgeu taken
            F3_BGEU: begin
                alu_op = ALU_SLTU;
                taken  = zero;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for the RV32I-subset datapath.
// Optional performance counters are built when MULTICYCLE_PERF_EN is defined.
module multicycle_ctrl
    import multicycle_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ir_write,
    output logic             adr_src,
    output logic             mem_req,
    output logic             mem_write,
    output logic             reg_write,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       imm_src,
    output logic [1:0]       result_src,
    output logic [2:0]       alu_control,
    output logic             illegal
`ifdef MULTICYCLE_PERF_EN
    ,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instret_count
`endif
);

    if (CNT_W < 1) begin : g_cnt_w_check
        $error("CNT_W must be at least 1");
    end

    state_t     state_q, state_d;
    ctrl_t      ctrl_q, ctrl_d;
    state_t     dispatch;
    logic       legal;
    logic       br_taken;
    logic [2:0] br_alu;

    mc_branch_eval u_branch_eval (
        .funct3 (funct3),
        .zero   (zero),
        .taken  (br_taken),
        .alu_op (br_alu)
    );

    always_comb begin
        legal    = 1'b0;
        dispatch = FETCH;
        case (opcode)
            OP_LOAD:   if (funct3 == F3_LBU)  begin legal = 1'b1; dispatch = MEMADR; end
            OP_STORE:  if (funct3 == F3_SB)   begin legal = 1'b1; dispatch = MEMADR; end
            OP_OP:     if (funct3 == F3_ADD)  begin legal = 1'b1; dispatch = EXEC_R; end
            OP_IMM:    if (funct3 == F3_ADD)  begin legal = 1'b1; dispatch = EXEC_I; end
            OP_LUI:                           begin legal = 1'b1; dispatch = LUI;    end
            OP_BRANCH: if (funct3 == F3_BNE || funct3 == F3_BGEU) begin
                legal    = 1'b1;
                dispatch = BRANCH;
            end
            OP_JAL:                           begin legal = 1'b1; dispatch = JAL;    end
            OP_JALR:   if (funct3 == F3_JALR) begin legal = 1'b1; dispatch = JALR;   end
            default: ;
        endcase
    end

    // Control word is registered from the next state; the in_fetch flag is
    // clear for one cycle after reset so the first request follows release.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:    if (ctrl_q.in_fetch && mem_ready) state_d = DECODE;
            DECODE:   state_d = dispatch;
            MEMADR:   state_d = (opcode == OP_LOAD) ? MEMREAD : MEMWRITE;
            MEMREAD:  if (mem_ready) state_d = MEMWB;
            MEMWB:    state_d = FETCH;
            MEMWRITE: if (mem_ready) state_d = FETCH;
            EXEC_R:   state_d = ALU_WB;
            EXEC_I:   state_d = ALU_WB;
            ALU_WB:   state_d = FETCH;
            LUI:      state_d = FETCH;
            BRANCH:   state_d = FETCH;
            JAL:      state_d = ALU_WB;
            JALR:     state_d = LINK;
            LINK:     state_d = ALU_WB;
            default:  state_d = FETCH;
        endcase
        ctrl_d = state_ctrl(state_d, opcode, br_alu);
    end

`ifdef MULTICYCLE_PERF_EN
    logic [CNT_W-1:0] cycle_q, cycle_d, instret_q, instret_d;

    always_comb begin
        cycle_d   = cycle_q + CNT_W'(1);
        instret_d = instret_q;
        if (state_d == FETCH && state_q != FETCH && state_q != DECODE) begin
            instret_d = instret_q + CNT_W'(1);
        end
    end

    assign cycle_count   = cycle_q;
    assign instret_count = instret_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= FETCH;
            ctrl_q    <= '0;
`ifdef MULTICYCLE_PERF_EN
            cycle_q   <= '0;
            instret_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
`ifdef MULTICYCLE_PERF_EN
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
`endif
        end
    end

    assign ir_write    = ctrl_q.in_fetch & mem_ready;
    assign pc_write    = ctrl_q.pc_write | (ctrl_q.in_fetch & mem_ready)
                       | (ctrl_q.in_branch & br_taken);
    assign adr_src     = ctrl_q.adr_src;
    assign mem_req     = ctrl_q.mem_req;
    assign mem_write   = ctrl_q.mem_write;
    assign reg_write   = ctrl_q.reg_write;
    assign alu_src_a   = ctrl_q.alu_src_a;
    assign alu_src_b   = ctrl_q.alu_src_b;
    assign imm_src     = ctrl_q.in_decode ? ((opcode == OP_JAL) ? IMM_J : IMM_B)
                                          : ctrl_q.imm_src;
    assign result_src  = ctrl_q.result_src;
    assign alu_control = ctrl_q.alu_control;
    assign illegal     = ctrl_q.in_decode & ~legal;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: table of instructions plus
// hand-written wait-state and reset sequences, checked cycle by cycle.
module tb_multicycle_ctrl;

    localparam int CNT_W = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] opcode = '0;
    logic [2:0] funct3 = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_write, ir_write, adr_src, mem_req, mem_write, reg_write, illegal;
    logic [1:0] alu_src_a, alu_src_b, result_src;
    logic [2:0] imm_src, alu_control;
`ifdef MULTICYCLE_PERF_EN
    logic [CNT_W-1:0] cycle_count, instret_count;
`endif

    multicycle_ctrl #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .opcode      (opcode),
        .funct3      (funct3),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .pc_write    (pc_write),
        .ir_write    (ir_write),
        .adr_src     (adr_src),
        .mem_req     (mem_req),
        .mem_write   (mem_write),
        .reg_write   (reg_write),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .imm_src     (imm_src),
        .result_src  (result_src),
        .alu_control (alu_control),
        .illegal     (illegal)
`ifdef MULTICYCLE_PERF_EN
        ,
        .cycle_count   (cycle_count),
        .instret_count (instret_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       adr_src;
        logic       mem_req;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] a;
        logic [1:0] b;
        logic [2:0] imm;
        logic [1:0] res;
        logic [2:0] alu;
        logic       illegal;
    } out_t;

    typedef enum int {S_F, S_D, S_MA, S_MR, S_MWB, S_MW, S_XR, S_XI, S_WB,
                      S_LUI, S_BR, S_JAL, S_JALR, S_LINK} bst_t;

    typedef struct {
        logic mr;
        bst_t st;
    } stim_t;

    typedef struct {
        string      name;
        logic [6:0] op;
        logic [2:0] f3;
        logic       z;
    } vec_t;

    out_t got;
    assign got = {pc_write, ir_write, adr_src, mem_req, mem_write, reg_write,
                  alu_src_a, alu_src_b, imm_src, result_src, alu_control, illegal};

    int   checks = 0;
    int   errors = 0;
    out_t sb[$];
    vec_t vecs[18];

    function automatic bit is_legal(logic [6:0] op, logic [2:0] f3);
        case (op)
            7'b0000011: return f3 == 3'b100;
            7'b0100011: return f3 == 3'b000;
            7'b0110011: return f3 == 3'b000;
            7'b0010011: return f3 == 3'b000;
            7'b0110111: return 1'b1;
            7'b1100011: return f3 == 3'b001 || f3 == 3'b111;
            7'b1101111: return 1'b1;
            7'b1100111: return f3 == 3'b000;
            default:    return 1'b0;
        endcase
    endfunction

    function automatic out_t exp_out(bst_t s, logic [6:0] op, logic [2:0] f3, logic z, logic mr);
        out_t o;
        o = '0;
        case (s)
            S_F:    begin o.mem_req = 1; o.b = 2'b10; o.res = 2'b10; o.ir_write = mr; o.pc_write = mr; end
            S_D:    begin
                o.a = 2'b01; o.b = 2'b01;
                o.imm = (op == 7'b1101111) ? 3'b100 : 3'b010;
                o.illegal = !is_legal(op, f3);
            end
            S_MA:   begin o.a = 2'b10; o.b = 2'b01; o.imm = (op == 7'b0000011) ? 3'b000 : 3'b001; end
            S_MR:   begin o.mem_req = 1; o.adr_src = 1; end
            S_MWB:  begin o.reg_write = 1; o.res = 2'b01; end
            S_MW:   begin o.mem_req = 1; o.mem_write = 1; o.adr_src = 1; end
            S_XR:   begin o.a = 2'b10; o.b = 2'b00; end
            S_XI:   begin o.a = 2'b10; o.b = 2'b01; o.imm = 3'b000; end
            S_WB:   begin o.reg_write = 1; o.res = 2'b00; end
            S_LUI:  begin o.b = 2'b01; o.imm = 3'b011; o.alu = 3'b010; o.res = 2'b10; o.reg_write = 1; end
            S_BR:   begin
                o.a = 2'b10; o.b = 2'b00; o.res = 2'b00;
                o.alu = (f3 == 3'b001) ? 3'b001 : 3'b011;
                o.pc_write = (f3 == 3'b001) ? !z : z;
            end
            S_JAL:  begin o.pc_write = 1; o.res = 2'b00; o.a = 2'b01; o.b = 2'b10; end
            S_JALR: begin o.a = 2'b10; o.b = 2'b01; o.imm = 3'b000; o.res = 2'b10; o.pc_write = 1; end
            S_LINK: begin o.a = 2'b01; o.b = 2'b10; end
            default: ;
        endcase
        return o;
    endfunction

    task automatic check_out(string name, out_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %b expected %b", name, $time, got, exp);
        end
    endtask

    task automatic check_zero(string name);
        checks++;
        if (got !== '0) begin
            errors++;
            $display("FAIL %s @%0t: got %b expected all zero", name, $time, got);
        end
    endtask

    // Starts just after a posedge; returns on the posedge after the last cycle run.
    task automatic run_instr(string name, logic [6:0] op, logic [2:0] f3, logic z,
                             int unsigned fwait, int unsigned mwait, int unsigned max_cyc);
        bst_t        seq[$];
        stim_t       stim[$];
        stim_t       s;
        int unsigned done;
        done = 0;
        seq.push_back(S_F);
        seq.push_back(S_D);
        if (is_legal(op, f3)) begin
            case (op)
                7'b0000011: begin seq.push_back(S_MA); seq.push_back(S_MR); seq.push_back(S_MWB); end
                7'b0100011: begin seq.push_back(S_MA); seq.push_back(S_MW); end
                7'b0110011: begin seq.push_back(S_XR); seq.push_back(S_WB); end
                7'b0010011: begin seq.push_back(S_XI); seq.push_back(S_WB); end
                7'b0110111: seq.push_back(S_LUI);
                7'b1100011: seq.push_back(S_BR);
                7'b1101111: begin seq.push_back(S_JAL); seq.push_back(S_WB); end
                7'b1100111: begin seq.push_back(S_JALR); seq.push_back(S_LINK); seq.push_back(S_WB); end
                default: ;
            endcase
        end
        foreach (seq[i]) begin
            int unsigned w;
            w = (seq[i] == S_F) ? fwait : ((seq[i] == S_MR || seq[i] == S_MW) ? mwait : 0);
            for (int unsigned k = 0; k < w; k++) stim.push_back('{1'b0, seq[i]});
            stim.push_back('{1'b1, seq[i]});
        end
        while (stim.size() > 0 && (max_cyc == 0 || done < max_cyc)) begin
            s = stim.pop_front();
            #1;
            opcode    = op;
            funct3    = f3;
            zero      = z;
            mem_ready = s.mr;
            sb.push_back(exp_out(s.st, op, f3, z, s.mr));
            @(negedge clk);
            check_out(name, sb.pop_front());
            @(posedge clk);
            done++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: no finish by %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
`ifdef MULTICYCLE_PERF_EN
        logic [CNT_W-1:0] c0, i0, dc, di;
`endif
        vecs[0]  = '{"add",        7'b0110011, 3'b000, 1'b0};
        vecs[1]  = '{"addi",       7'b0010011, 3'b000, 1'b0};
        vecs[2]  = '{"lbu",        7'b0000011, 3'b100, 1'b0};
        vecs[3]  = '{"sb",         7'b0100011, 3'b000, 1'b0};
        vecs[4]  = '{"lui",        7'b0110111, 3'b101, 1'b0};
        vecs[5]  = '{"bne_taken",  7'b1100011, 3'b001, 1'b0};
        vecs[6]  = '{"bne_not",    7'b1100011, 3'b001, 1'b1};
        vecs[7]  = '{"bgeu_not",   7'b1100011, 3'b111, 1'b0};
        vecs[8]  = '{"bgeu_taken", 7'b1100011, 3'b111, 1'b1};
        vecs[9]  = '{"jal",        7'b1101111, 3'b011, 1'b0};
        vecs[10] = '{"jalr",       7'b1100111, 3'b000, 1'b0};
        vecs[11] = '{"ecall_ill",  7'b1110011, 3'b000, 1'b0};
        vecs[12] = '{"slli_ill",   7'b0010011, 3'b001, 1'b0};
        vecs[13] = '{"lb_ill",     7'b0000011, 3'b000, 1'b0};
        vecs[14] = '{"beq_ill",    7'b1100011, 3'b000, 1'b0};
        vecs[15] = '{"sw_ill",     7'b0100011, 3'b010, 1'b0};
        vecs[16] = '{"xor_ill",    7'b0110011, 3'b100, 1'b0};
        vecs[17] = '{"jalr_ill",   7'b1100111, 3'b010, 1'b0};

        #1;
        check_zero("reset_initial");
        mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero("reset_held_mem_ready1");
`ifdef MULTICYCLE_PERF_EN
        checks++;
        if (cycle_count !== '0 || instret_count !== '0) begin
            errors++;
            $display("FAIL perf_reset: got cycle=%0d instret=%0d expected 0 0", cycle_count, instret_count);
        end
`endif
        mem_ready = 1'b0;
        rst = 1'b0;
        @(posedge clk);

        foreach (vecs[i]) run_instr(vecs[i].name, vecs[i].op, vecs[i].f3, vecs[i].z, 0, 0, 0);

        run_instr("addi_fetch_wait2", 7'b0010011, 3'b000, 1'b0, 2, 0, 0);
        run_instr("lbu_memread_wait3", 7'b0000011, 3'b100, 1'b0, 0, 3, 0);
        run_instr("sb_memwrite_wait2", 7'b0100011, 3'b000, 1'b0, 0, 2, 0);
        run_instr("jalr_fetch_wait1", 7'b1100111, 3'b000, 1'b0, 1, 0, 0);

`ifdef MULTICYCLE_PERF_EN
        #1;
        c0 = cycle_count;
        i0 = instret_count;
        run_instr("ecall_perf", 7'b1110011, 3'b000, 1'b0, 0, 0, 0);
        #1;
        dc = cycle_count - c0;
        di = instret_count - i0;
        checks++;
        if (dc !== CNT_W'(2) || di !== CNT_W'(0)) begin
            errors++;
            $display("FAIL perf_illegal: got dcycle=%0d dinstret=%0d expected 2 0", dc, di);
        end
        c0 = cycle_count;
        i0 = instret_count;
        run_instr("lbu_perf", 7'b0000011, 3'b100, 1'b0, 0, 1, 0);
        #1;
        dc = cycle_count - c0;
        di = instret_count - i0;
        checks++;
        if (dc !== CNT_W'(6) || di !== CNT_W'(1)) begin
            errors++;
            $display("FAIL perf_lbu: got dcycle=%0d dinstret=%0d expected 6 1", dc, di);
        end
`endif

        // Reset lands while MEMREAD is waiting on memory
        run_instr("lbu_pre_rst", 7'b0000011, 3'b100, 1'b0, 0, 5, 4);
        #1;
        mem_ready = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        check_zero("rst_async_memread");
        @(negedge clk);
        check_zero("rst_hold");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        run_instr("addi_after_rst", 7'b0010011, 3'b000, 1'b0, 0, 0, 0);
        run_instr("tail_fetch", 7'b0110111, 3'b000, 1'b0, 0, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle control FSM for the RV32I subset datapath: add, addi, lbu, sb, lui, bne, bgeu, jal, jalr. Each instruction is sequenced over several cycles on one shared ALU and one shared instruction/data memory port. The block drives PC/IR write enables, the memory request handshake, the register-file write enable and the datapath mux selects. It sits between the instruction register fields and the multicycle datapath, and replaces single-cycle decode for the multicycle core.

## Interface
Parameters:
- `CNT_W`, default 32: width of the performance counters. Only used under `MULTICYCLE_PERF_EN`.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-high reset.
- `opcode` in 7: IR[6:0]. Stable from DECODE until the return to FETCH.
- `funct3` in 3: IR[14:12].
- `zero` in 1: ALU zero flag from the current cycle.
- `mem_ready` in 1: memory completes the current access this cycle. Ignored when `mem_req`=0.
- `pc_write` out 1: load PC from the result mux.
- `ir_write` out 1: latch IR and OldPC.
- `adr_src` out 1: memory address select. 0=PC, 1=ALUOut.
- `mem_req` out 1: memory access request.
- `mem_write` out 1: the access is a byte store.
- `reg_write` out 1: register-file write of the result mux.
- `alu_src_a` out 2: 00=PC, 01=OldPC, 10=rs1.
- `alu_src_b` out 2: 00=rs2, 01=ImmExt, 10=constant 4.
- `imm_src` out 3: 000=I, 001=S, 010=B, 011=U, 100=J.
- `result_src` out 2: 00=ALUOut, 01=ReadData, 10=ALUResult.
- `alu_control` out 3: 000=ADD, 001=SUB, 010=PASS_B, 011=SLTU.
- `illegal` out 1: one-cycle pulse on an unsupported encoding.
- `cycle_count` out CNT_W: present only under `MULTICYCLE_PERF_EN`.
- `instret_count` out CNT_W: present only under `MULTICYCLE_PERF_EN`.

## Operation
Outputs are Moore-style from the state. Exceptions: the FETCH and MEMREAD/MEMWRITE strobes are qualified by `mem_ready`, and BRANCH `pc_write` is qualified by `zero`. Any select not listed for a state is 0.

- **FETCH:** `mem_req`=1, `adr_src`=0. Waits while `mem_ready`=0. When `mem_ready`=1: `ir_write`=1, `pc_write`=1, ALU computes PC+4 (a=00, b=10, ADD), `result_src`=10, next state DECODE.
- **DECODE:** ALU computes OldPC+imm into ALUOut (a=01, b=01, ADD). `imm_src`=J if the opcode is jal, otherwise B. Dispatch:
  - load/store → MEMADR
  - op → EXEC_R, op-imm → EXEC_I
  - lui → LUI
  - branch → BRANCH
  - jal → JAL, jalr → JALR
  - unsupported opcode/funct3 → `illegal`=1, then FETCH. Treated as NOP, nothing written.
- **MEMADR:** rs1+imm (imm I for lbu, S for sb). Next MEMREAD for lbu, MEMWRITE for sb.
- **MEMREAD:** `mem_req`=1, `adr_src`=1. Hold until `mem_ready`, then MEMWB.
- **MEMWB:** `reg_write`=1, `result_src`=01. Next FETCH.
- **MEMWRITE:** `mem_req`=1, `mem_write`=1, `adr_src`=1. Hold until `mem_ready`, then FETCH.
- **EXEC_R:** rs1+rs2. **EXEC_I:** rs1+immI. Both go to ALU_WB.
- **ALU_WB:** `reg_write`=1, `result_src`=00. Next FETCH.
- **LUI:** b=imm U, PASS_B, `result_src`=10, `reg_write`=1. Next FETCH.
- **BRANCH:** rs1 vs rs2. bne uses SUB and is taken when `zero`=0. bgeu uses SLTU and is taken when `zero`=1. `pc_write`=taken, `result_src`=00. Next FETCH.
- **JAL:** `pc_write`=1 from ALUOut. The ALU computes OldPC+4 into ALUOut in the same cycle. Next ALU_WB.
- **JALR:** rs1+immI, `result_src`=10, `pc_write`=1. The datapath clears bit 0. Next LINK.
- **LINK:** OldPC+4 into ALUOut. Next ALU_WB.
- **Supported set:** add f3=000 (funct7 not checked), addi 000, lbu 100, sb 000, bne 001, bgeu 111, jalr 000. lui and jal accept any funct3.

## Timing
- **Reset:** while `rst`=1, state=FETCH and every output is 0, including `mem_req`. Reset asserted mid-instruction forces FETCH asynchronously and abandons any pending memory access with no register write. The first fetch request appears the cycle after deassertion.
- **Cycles per instruction with `mem_ready` tied to 1:**
  - branch, lui: 3
  - add, addi, sb, jal: 4
  - lbu, jalr: 5
  - illegal: 2
- **Memory wait states:** each cycle of `mem_ready`=0 adds one cycle in FETCH, MEMREAD or MEMWRITE. All selects are held constant while waiting.
- **Strobe rules:**
  - `mem_write`=1 only with `mem_req`=1 and `adr_src`=1.
  - `pc_write` and `reg_write` are never both 1 except in JAL/JALR, where `reg_write`=0.

## Configuration
- **`MULTICYCLE_PERF_EN` defined:**
  - `cycle_count` increments every cycle while not in reset.
  - `instret_count` increments on each completed legal instruction, i.e. on the transition back into FETCH from any state other than DECODE.
  - Both counters reset to 0 and wrap modulo 2^CNT_W.
- **Undefined:** counters and ports absent. FSM behaviour is identical.

## Structure
- **Shared package `multicycle_pkg`:**
  - state enum: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXEC_R, EXEC_I, ALU_WB, LUI, BRANCH, JAL, JALR, LINK
  - opcode constants
  - ALU_*, RES_* encodings
  - src-A/src-B and ImmSrc encodings
- **Sub-module `mc_branch_eval`:** combinational. Inputs funct3 and `zero`; outputs taken and the branch ALU op.

## Test plan
- `rst` pulse mid-MEMREAD → all outputs 0 immediately. After release, FETCH with `mem_req`=1 and `adr_src`=0.
- addi with `mem_ready`=1 → states FETCH, DECODE, EXEC_I, ALU_WB. `reg_write`=1 only in cycle 4; next cycle is FETCH.
- lbu, with `mem_ready` held 0 for 3 cycles in MEMREAD → MEMREAD lasts 4 cycles with `mem_req`=1 and `adr_src`=1 constant. MEMWB has `result_src`=01. Total 8 cycles.
- bne with `zero`=0 → `pc_write`=1 and `result_src`=00 in cycle 3. bgeu with `zero`=0 → `pc_write`=0.
- jalr → cycle 3 `pc_write`=1 with `result_src`=10; cycle 4 LINK; cycle 5 `reg_write`=1.
- opcode 7'b1110011 → `illegal`=1 in DECODE only, no writes, FETCH next. Under `MULTICYCLE_PERF_EN`, `instret_count` is unchanged and `cycle_count` advances by 2.
